fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the control decoder. Holds the program counter, addresses the synchronous-read instruction ROM, and presents each fetched instruction to the decoder with a valid flag. Consumes the decoder's `Branch` output and the branch target to redirect fetch with no bubble. Provides a start/done handshake and a retired-instruction counter for the test harness.

## Interface
- `PC_W`, 10, program counter and ROM address width
- `IW`, 9, instruction width; opcode is `instr[IW-1:IW-4]`
- `HALT_INSTR`, 9'h1FF, encoding that terminates the program
- `CNT_W`, 16, retired-counter width

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin execution at PC 0 (sampled in IDLE/DONE)
- `stall`  in  1  hold the current instruction (downstream not ready)
- `branch`  in  1  from control decoder `Branch`; taken-branch request
- `branch_target`  in  PC_W  absolute target PC
- `imem_addr`  out  PC_W  ROM read address (combinational)
- `imem_data`  in  IW  ROM data, valid the cycle after its address is presented
- `instr`  out  IW  instruction to decoder (= `imem_data`)
- `instr_pc`  out  PC_W  PC of `instr`
- `instr_valid`  out  1  `instr` is live; downstream gates writes with it
- `busy`  out  1  state == RUN
- `done`  out  1  halt retired; held until the next start
- `retired`  out  CNT_W  count of retired instructions

## Operation
- Registers: `state` {IDLE, RUN, DONE}, `pc_q`, `instr_pc`, `valid_q`, `done_q`, `retired`.
- `take = (state==RUN) & valid_q & branch & ~stall & ~halt`, where `halt = valid_q & (imem_data==HALT_INSTR)`.
- `imem_addr` mux, priority order:
  - IDLE/DONE: 0
  - `take`: `branch_target`
  - `stall`: `instr_pc`, so the ROM re-reads and `imem_data` holds
  - otherwise: `pc_q`
- IDLE/DONE on `start`: next state RUN, `instr_pc<=0`, `pc_q<=1`, `valid_q<=1`, `done_q<=0`, `retired<=0`. Without `start`, all registers hold and `pc_q` is 0.
- RUN, `stall`: all registers hold. `branch` is ignored.
- RUN, `halt & ~stall`: `retired++`, `valid_q<=0`, `done_q<=1`, `pc_q<=0`, next state DONE. Halt has priority over `branch`.
- RUN, `take`: `instr_pc<=branch_target`, `pc_q<=branch_target+1`, `valid_q<=1`, `retired++`.
- RUN, otherwise: `instr_pc<=pc_q`, `pc_q<=pc_q+1`, `valid_q<=1`, `retired++` (when `valid_q`).
- `start` during RUN is ignored.
- Arithmetic:
  - `pc_q` increment wraps modulo 2^PC_W; address 2^PC_W−1 is followed by 0.
  - `retired` wraps modulo 2^CNT_W.

## Timing
- Reset values (async, immediate): state IDLE, `pc_q=0`, `instr_pc=0`, `valid_q=0`, `instr_valid=0`, `done=0`, `busy=0`, `retired=0`. `imem_addr=0`.
- Reset asserted mid-RUN aborts at once. No instruction is valid on the first edge after release.
- Start latency: `start` high at edge N, so `instr_valid=1` with `instr=mem[0]` in cycle N+1.
- Sequential throughput: one instruction per cycle.
- Taken branch: zero bubbles. `mem[target]` is valid the cycle after the branch instruction.
- `branch` → `imem_addr` is a combinational path and lies within the single-cycle budget.
- Halt: `done` rises the cycle after the halt instruction is presented. `instr_valid` drops in that same cycle.
- `instr_valid`, `busy` and `done` are registered outputs. `instr` is not registered: it is ROM output.

## Test plan
- Reset, then `start` pulse; ROM holds 0:ADD, 1:OR, 2:1FF → `instr_pc` 0,1,2 on consecutive cycles, `done=1` one cycle after pc 2, `retired=3`, `busy=0`.
- Taken branch: pc 3 = BEQ, `branch=1`, target 0x040 → next `instr_pc=0x040`, then 0x041. No invalid cycle. Pc 4 never appears.
- Stall: assert `stall` 3 cycles while `instr_pc=5` → `instr`, `instr_pc` and `retired` are constant. `imem_addr=5`. Release gives pc 6 next.
- Stall with `branch=1` held: target is not taken until stall drops. It is taken on the first unstalled cycle.
- Wrap: `branch_target=0x3FF`, no halt → `instr_pc` 0x3FF then 0x000.
- Async reset asserted mid-RUN at pc 0x020 → all outputs at reset values before the next edge. A subsequent `start` fetches from pc 0 and `retired` restarts at 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction ROM and
// hands each fetched instruction to the decoder, redirecting on taken branches with no bubble.
module fetch_unit #(
   parameter int              PC_W       = 10,
   parameter int              IW         = 9,
   parameter logic [IW-1:0]   HALT_INSTR = 9'h1FF,
   parameter int              CNT_W      = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               stall,
   input  logic               branch,
   input  logic [PC_W-1:0]    branch_target,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [IW-1:0]      imem_data,
   output logic [IW-1:0]      instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   retired
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_reg, state_next;
   logic [PC_W-1:0]  pc_reg, pc_next;
   logic [PC_W-1:0]  instr_pc_reg, instr_pc_next;
   logic             valid_reg, valid_next;
   logic             done_reg, done_next;
   logic             busy_reg;
   logic [CNT_W-1:0] retired_reg, retired_next;

   logic running;
   logic halt;
   logic take;

   assign running = (state_reg == RUN);
   assign halt    = valid_reg & (imem_data == HALT_INSTR);
   assign take    = running & valid_reg & branch & ~stall & ~halt;

   // The ROM is addressed one cycle ahead; on stall we re-read instr_pc so imem_data holds.
   always_comb begin
      imem_addr = pc_reg;
      if (!running) begin
         imem_addr = '0;
      end else if (take) begin
         imem_addr = branch_target;
      end else if (stall) begin
         imem_addr = instr_pc_reg;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      instr_pc_next = instr_pc_reg;
      valid_next    = valid_reg;
      done_next     = done_reg;
      retired_next  = retired_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next    = RUN;
               instr_pc_next = '0;
               pc_next       = {{(PC_W-1){1'b0}}, 1'b1};
               valid_next    = 1'b1;
               done_next     = 1'b0;
               retired_next  = '0;
            end
         end
         RUN: begin
            if (!stall) begin
               // Halt wins over a simultaneous branch request.
               if (halt) begin
                  state_next   = DONE;
                  valid_next   = 1'b0;
                  done_next    = 1'b1;
                  pc_next      = '0;
                  retired_next = retired_reg + 1'b1;
               end else if (take) begin
                  instr_pc_next = branch_target;
                  pc_next       = branch_target + 1'b1;
                  valid_next    = 1'b1;
                  retired_next  = retired_reg + 1'b1;
               end else begin
                  instr_pc_next = pc_reg;
                  pc_next       = pc_reg + 1'b1;
                  valid_next    = 1'b1;
                  if (valid_reg) begin
                     retired_next = retired_reg + 1'b1;
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
            pc_next    = '0;
            valid_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         pc_reg       <= '0;
         instr_pc_reg <= '0;
         valid_reg    <= 1'b0;
         done_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         retired_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         instr_pc_reg <= instr_pc_next;
         valid_reg    <= valid_next;
         done_reg     <= done_next;
         busy_reg     <= (state_next == RUN);
         retired_reg  <= retired_next;
      end
   end

   assign instr       = imem_data;
   assign instr_pc    = instr_pc_reg;
   assign instr_valid = valid_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign retired     = retired_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: synchronous ROM model, program-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized programs.
module tb_fetch_unit;

   localparam int PC_W  = 10;
   localparam int IW    = 9;
   localparam int CNT_W = 16;
   localparam logic [IW-1:0] HALT   = 9'h1FF;
   localparam logic [IW-1:0] OP_ADD = 9'h010;
   localparam logic [IW-1:0] OP_OR  = 9'h031;
   localparam logic [IW-1:0] OP_BEQ = 9'h0C7;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             stall = 1'b0;
   logic             branch = 1'b0;
   logic [PC_W-1:0]  branch_target = '0;
   logic [PC_W-1:0]  imem_addr;
   logic [IW-1:0]    imem_data;
   logic [IW-1:0]    instr;
   logic [PC_W-1:0]  instr_pc;
   logic             instr_valid;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] retired;

   logic [IW-1:0] mem [0:(1<<PC_W)-1];

   // Program-level model: which pc is presented, whether a program runs, what has retired.
   bit               m_run;
   bit               m_done;
   logic [PC_W-1:0]  m_pc;
   logic [CNT_W-1:0] m_retired;

   int  n_pass  = 0;
   int  n_total = 0;
   bit  chk_en  = 1'b0;

   fetch_unit #(
      .PC_W(PC_W), .IW(IW), .HALT_INSTR(HALT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
      .branch(branch), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .busy(busy), .done(done), .retired(retired)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_data <= mem[imem_addr];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
   endfunction

   task automatic model_reset();
      m_run = 1'b0; m_done = 1'b0; m_pc = '0; m_retired = '0;
   endtask

   task automatic model_step();
      if (!m_run) begin
         if (start) begin
            m_run = 1'b1; m_done = 1'b0; m_pc = '0; m_retired = '0;
         end
      end else if (!stall) begin
         m_retired = m_retired + 16'd1;
         if (mem[m_pc] == HALT) begin
            m_run = 1'b0; m_done = 1'b1;
         end else if (branch) begin
            m_pc = branch_target;
         end else begin
            m_pc = m_pc + 10'd1;
         end
      end
   endtask

   // Address the ROM must see now so that next cycle presents the correct instruction.
   function automatic logic [PC_W-1:0] exp_addr();
      if (!m_run) return '0;
      if (stall) return m_pc;
      if (branch && mem[m_pc] != HALT) return branch_target;
      return m_pc + 10'd1;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("valid", 32'(instr_valid), 32'(m_run));
         check("busy", 32'(busy), 32'(m_run));
         check("done", 32'(done), 32'(m_done));
         check("retired", 32'(retired), 32'(m_retired));
         check("instr_pc", 32'(instr_pc), 32'(m_pc));
         check("imem_addr", 32'(imem_addr), 32'(exp_addr()));
         if (m_run) check("instr", 32'(instr), 32'(mem[m_pc]));
      end
   end

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_step();
      #1;
   endtask

   task automatic fill_plain();
      for (int i = 0; i < (1 << PC_W); i++) mem[i] = 9'($urandom_range(0, 510));
   endtask

   initial begin
      int cyc;
      fill_plain();
      model_reset();
      chk_en = 1'b1;
      tick(); tick();
      reset_n = 1'b1;
      tick();
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_retired", 32'(retired), 32'h0);
      check("rst_addr", 32'(imem_addr), 32'h0);
      $display("reset: valid=%0d busy=%0d done=%0d", instr_valid, busy, done);

      // Three-instruction program ending in halt.
      mem[0] = OP_ADD; mem[1] = OP_OR; mem[2] = HALT;
      start = 1'b1; tick(); start = 1'b0;
      check("t1_pc0", 32'(instr_pc), 32'h0);
      check("t1_instr0", 32'(instr), 32'(OP_ADD));
      check("t1_valid0", 32'(instr_valid), 32'h1);
      tick();
      check("t1_pc1", 32'(instr_pc), 32'h1);
      tick();
      check("t1_pc2", 32'(instr_pc), 32'h2);
      check("t1_instr2", 32'(instr), 32'(HALT));
      tick();
      check("t1_done", 32'(done), 32'h1);
      check("t1_valid_off", 32'(instr_valid), 32'h0);
      check("t1_retired", 32'(retired), 32'h3);
      check("t1_busy", 32'(busy), 32'h0);
      $display("halt program: retired=%0d done=%0d", retired, done);

      // Branch, stall, stalled branch, wrap.
      fill_plain();
      mem[3] = OP_BEQ;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      check("t2_pc3", 32'(instr_pc), 32'h3);
      branch = 1'b1; branch_target = 10'h040; tick(); branch = 1'b0;
      check("t2_br_pc", 32'(instr_pc), 32'h040);
      check("t2_br_valid", 32'(instr_valid), 32'h1);
      tick();
      check("t2_br_next", 32'(instr_pc), 32'h041);
      $display("branch: pc3 -> %0h", 10'h040);
      branch = 1'b1; branch_target = 10'd5; tick(); branch = 1'b0;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_stall_pc", 32'(instr_pc), 32'h5);
         check("t3_stall_instr", 32'(instr), 32'(mem[5]));
         check("t3_stall_ret", 32'(retired), 32'd6);
         check("t3_stall_addr", 32'(imem_addr), 32'h5);
      end
      stall = 1'b0; tick();
      check("t3_release_pc", 32'(instr_pc), 32'h6);
      check("t3_release_ret", 32'(retired), 32'd7);
      $display("stall: held pc 5 for 3 cycles");
      stall = 1'b1; branch = 1'b1; branch_target = 10'h100;
      tick(); tick();
      check("t4_stallbr_pc", 32'(instr_pc), 32'h6);
      check("t4_stallbr_addr", 32'(imem_addr), 32'h6);
      stall = 1'b0; tick();
      check("t4_taken_pc", 32'(instr_pc), 32'h100);
      $display("stalled branch: taken after release to %0h", instr_pc);
      branch_target = 10'h3FF; tick(); branch = 1'b0;
      check("t5_wrap_top", 32'(instr_pc), 32'h3FF);
      tick();
      check("t5_wrap_zero", 32'(instr_pc), 32'h000);
      $display("wrap: 3ff -> 000");

      // Asynchronous reset in the middle of a run.
      branch = 1'b1; branch_target = 10'h020; tick(); branch = 1'b0;
      check("t6_pc20", 32'(instr_pc), 32'h020);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("t6_valid", 32'(instr_valid), 32'h0);
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_done", 32'(done), 32'h0);
      check("t6_retired", 32'(retired), 32'h0);
      check("t6_pc", 32'(instr_pc), 32'h0);
      check("t6_addr", 32'(imem_addr), 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      check("t6_no_valid", 32'(instr_valid), 32'h0);
      start = 1'b1; tick(); start = 1'b0;
      check("t6_restart_pc", 32'(instr_pc), 32'h0);
      check("t6_restart_ret", 32'(retired), 32'h0);
      tick();
      check("t6_restart_ret1", 32'(retired), 32'h1);
      $display("async reset: restart from pc 0");
      reset_n = 1'b0; model_reset(); tick(); reset_n = 1'b1; tick();

      // Randomized programs with stalls, branches and ignored start pulses.
      for (int p = 0; p < 20; p++) begin
         for (int i = 0; i < (1 << PC_W); i++)
            mem[i] = ($urandom_range(0, 47) == 0) ? HALT : 9'($urandom_range(0, 510));
         start = 1'b1; tick(); start = 1'b0;
         cyc = 0;
         while (m_run && cyc < 300) begin
            stall  = ($urandom_range(0, 3) == 0);
            branch = ($urandom_range(0, 4) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1016, 1023))
                                                        : 10'($urandom);
            start  = ($urandom_range(0, 15) == 0);
            tick();
            cyc++;
         end
         start = 1'b0; stall = 1'b0; branch = 1'b0;
         $display("prog %0d: cycles=%0d retired=%0d halted=%0d", p, cyc, m_retired, m_done);
         if (m_run) begin
            reset_n = 1'b0; model_reset(); tick(); reset_n = 1'b1; tick();
         end
         tick();
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
